mmap_sum_app: RTL and testbench

Memory-mapped application block sitting directly downstream of the AXI-Lite slave shim; it consumes that shim's single-beat write/read strobes (`mmap_*`) and returns registered read data. It holds a small control/status register file and runs an arithmetic-series accumulator: the host programs START and SIZE, writes GO, and polls DONE and RESULT. The block gives the shim a fixed one-cycle read latency.

---
 rtl/mmap_sum_pkg.sv | 23 ++
 rtl/mmap_sum_core.sv | 86 ++++++++
 rtl/mmap_sum_app.sv | 96 +++++++++
 tb/tb_mmap_sum_app.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mmap_sum_pkg.sv
// Shared register offsets, constants and FSM encoding for the memory-mapped
// arithmetic-series accumulator.
package mmap_sum_pkg;

    localparam int DATA_W = 32;

    // Word offsets, i.e. addr[5:2] of the byte address
    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_SIZE   = 4'h1;
    localparam logic [3:0] REG_START  = 4'h2;
    localparam logic [3:0] REG_RESULT = 4'h3;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_CYCLES = 4'h5;

    localparam logic [DATA_W-1:0] UNIMPL_VALUE = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sum_state_t;

endpackage

// File: rtl/mmap_sum_core.sv
// Run-control FSM and accumulate datapath: sums SIZE consecutive terms
// beginning at START, one term per clock, with 32-bit wrap.
module mmap_sum_core
    import mmap_sum_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic [DATA_W-1:0] size,
    input  logic [DATA_W-1:0] start,
    output sum_state_t        state,
    output logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] cycles,
    output logic              done
);

    sum_state_t        state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] term_q, term_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] cycles_q, cycles_d;
    logic              done_q, done_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            term_q   <= '0;
            cnt_q    <= '0;
            cycles_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            term_q   <= term_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        term_d   = term_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        done_d   = done_q;
        case (state_q)
            IDLE, DONE: begin
                // A zero-length run still passes through RUN for one cycle,
                // so DONE always arrives at least one edge after GO.
                if (go) begin
                    cnt_d    = size;
                    term_d   = start;
                    acc_d    = '0;
                    cycles_d = '0;
                    done_d   = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    acc_d    = acc_q + term_q;
                    term_d   = term_q + 32'd1;
                    cnt_d    = cnt_q - 32'd1;
                    cycles_d = cycles_q + 32'd1;
                    if (cnt_q == 32'd1) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign state  = state_q;
    assign acc    = acc_q;
    assign cycles = cycles_q;
    assign done   = done_q;

endmodule

// File: rtl/mmap_sum_app.sv
// Register file, address decode and one-cycle registered read mux in front of
// the series accumulator core.
module mmap_sum_app
    import mmap_sum_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_aresetn,
    input  logic        mmap_wr_en,
    input  logic [31:0] mmap_wr_addr,
    input  logic [31:0] mmap_wr_data,
    input  logic        mmap_rd_en,
    input  logic [31:0] mmap_rd_addr,
    output logic [31:0] mmap_rd_data,
    output logic        done
);

    logic [DATA_W-1:0] size_q, size_d;
    logic [DATA_W-1:0] start_q, start_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DATA_W-1:0] rd_val;

    logic              wr_hit, rd_hit, go;
    logic [3:0]        wr_off, rd_off;

    sum_state_t        core_state;
    logic [DATA_W-1:0] core_acc;
    logic [DATA_W-1:0] core_cycles;
    logic              core_done;

    // Byte lanes within a word carry no meaning here
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mmap_wr_addr[1:0], mmap_rd_addr[1:0]};

    assign wr_hit = mmap_wr_en && (mmap_wr_addr[31:6] == BASE_ADDR[31:6]);
    assign rd_hit = (mmap_rd_addr[31:6] == BASE_ADDR[31:6]);
    assign wr_off = mmap_wr_addr[5:2];
    assign rd_off = mmap_rd_addr[5:2];
    assign go     = wr_hit && (wr_off == REG_CTRL) && mmap_wr_data[0];

    mmap_sum_core u_core (
        .clk    (s_axi_aclk),
        .rst_n  (s_axi_aresetn),
        .go     (go),
        .size   (size_q),
        .start  (start_q),
        .state  (core_state),
        .acc    (core_acc),
        .cycles (core_cycles),
        .done   (core_done)
    );

    always_comb begin
        size_d  = size_q;
        start_d = start_q;
        if (wr_hit && (core_state != RUN)) begin
            if (wr_off == REG_SIZE)  size_d  = mmap_wr_data;
            if (wr_off == REG_START) start_d = mmap_wr_data;
        end
    end

    // Read mux samples current register contents, so a same-cycle write is
    // not yet visible to the read.
    always_comb begin
        rd_val = UNIMPL_VALUE;
        if (rd_hit) begin
            case (rd_off)
                REG_CTRL:   rd_val = {30'b0, core_state};
                REG_SIZE:   rd_val = size_q;
                REG_START:  rd_val = start_q;
                REG_RESULT: rd_val = core_acc;
                REG_STATUS: rd_val = {31'b0, core_done};
                REG_CYCLES: rd_val = core_cycles;
                default:    rd_val = UNIMPL_VALUE;
            endcase
        end
        rd_data_d = mmap_rd_en ? rd_val : rd_data_q;
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            size_q    <= '0;
            start_q   <= '0;
            rd_data_q <= '0;
        end else begin
            size_q    <= size_d;
            start_q   <= start_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign mmap_rd_data = rd_data_q;
    assign done         = core_done;

endmodule

// File: tb/tb_mmap_sum_app.sv
// Directed bench for mmap_sum_app: register map, run lengths, wrap, RUN-time
// write protection, read/write collision and mid-run reset.
module tb_mmap_sum_app;

    localparam logic [31:0] BASE = 32'h4000_1000;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_addr = '0;
    logic [31:0] rd_data;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] off;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [31:0] start;
        logic [31:0] size;
        logic [31:0] result;
        int          edges;
    } run_vec_t;

    rd_vec_t  rd_tbl[16];
    run_vec_t run_tbl[4];

    mmap_sum_app #(.BASE_ADDR(BASE)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .mmap_wr_en    (wr_en),
        .mmap_wr_addr  (wr_addr),
        .mmap_wr_data  (wr_data),
        .mmap_rd_en    (rd_en),
        .mmap_rd_addr  (rd_addr),
        .mmap_rd_data  (rd_data),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = BASE + off;
        wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        rd_en   = 1'b1;
        rd_addr = addr;
        @(posedge clk); #1;
        rd_en = 1'b0;
        check(name, rd_data, exp);
    endtask

    // Counts edges until done rises; expects it exactly at edge number exp
    task automatic wait_done(input string name, input int exp);
        int n;
        n = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (done) begin
                n = i;
                break;
            end
        end
        check(name, n, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            rd_tbl[i].off = 32'(i * 4);
            rd_tbl[i].exp = (i < 6) ? 32'h0 : DEAD;
        end
        run_tbl[0] = '{start: 32'd1,          size: 32'd10, result: 32'd55,   edges: 10};
        run_tbl[1] = '{start: 32'hFFFF_FFFF,  size: 32'd3,  result: 32'h0,    edges: 3};
        run_tbl[2] = '{start: 32'd9,          size: 32'd0,  result: 32'h0,    edges: 1};
        run_tbl[3] = '{start: 32'd5,          size: 32'd4,  result: 32'd26,   edges: 4};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check("reset_rd_data", rd_data, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        for (int i = 0; i < 16; i++)
            rd_chk($sformatf("reset_rd_off_%02h", rd_tbl[i].off), BASE + rd_tbl[i].off, rd_tbl[i].exp);

        for (int r = 0; r < 4; r++) begin
            wr(32'h08, run_tbl[r].start);
            wr(32'h04, run_tbl[r].size);
            wr(32'h00, 32'h1);
            wait_done($sformatf("run%0d_done_edge", r), run_tbl[r].edges);
            rd_chk($sformatf("run%0d_result", r), BASE + 32'h0C, run_tbl[r].result);
            rd_chk($sformatf("run%0d_cycles", r), BASE + 32'h14, run_tbl[r].size);
            rd_chk($sformatf("run%0d_ctrl", r), BASE + 32'h00, 32'd2);
            rd_chk($sformatf("run%0d_status", r), BASE + 32'h10, 32'd1);
        end

        // Writes during RUN are ignored; RESULT is live
        wr(32'h08, 32'd1);
        wr(32'h04, 32'd100);
        wr(32'h00, 32'h1);
        check("go_clears_done", {31'b0, done}, 32'h0);
        wr(32'h04, 32'd5);
        wr(32'h08, 32'd7);
        wr(32'h00, 32'h1);
        rd_chk("midrun_partial_result", BASE + 32'h0C, 32'd6);
        wait_done("midrun_done_edge", 96);
        rd_chk("midrun_result", BASE + 32'h0C, 32'd5050);
        rd_chk("midrun_size_kept", BASE + 32'h04, 32'd100);
        rd_chk("midrun_start_kept", BASE + 32'h08, 32'd1);
        wr(32'h00, 32'h1);
        wait_done("restart_done_edge", 100);
        rd_chk("restart_result", BASE + 32'h0C, 32'd5050);

        // Read data holds while rd_en is low
        repeat (3) @(posedge clk);
        #1 check("rd_data_hold", rd_data, 32'd5050);

        // Same-cycle read and write of SIZE returns the old value
        wr_en = 1'b1; wr_addr = BASE + 32'h04; wr_data = 32'd77;
        rd_en = 1'b1; rd_addr = BASE + 32'h04;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        check("collide_pre_write", rd_data, 32'd100);
        rd_chk("collide_post_write", BASE + 32'h04, 32'd77);

        // Reset in the middle of a run
        wr(32'h08, 32'd1);
        wr(32'h04, 32'd20);
        wr(32'h00, 32'h1);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midreset_done", {31'b0, done}, 32'h0);
        check("midreset_rd_data", rd_data, 32'h0);
        for (int i = 0; i < 6; i++)
            rd_chk($sformatf("midreset_off_%02h", rd_tbl[i].off), BASE + rd_tbl[i].off, 32'h0);

        // Out-of-window accesses
        wr(32'h44, 32'h1234);
        wr(32'h40, 32'h1);
        rd_chk("miss_size_unchanged", BASE + 32'h04, 32'h0);
        rd_chk("miss_ctrl_idle", BASE + 32'h00, 32'h0);
        rd_chk("miss_read", BASE + 32'h44, DEAD);
        rd_chk("byte_lane_ignored", BASE + 32'h07, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
